// File: rtl/hand_digit_scanner_pkg.sv
// rtl/hand_digit_scanner_pkg.sv - shared card types and display constants
package hand_digit_scanner_pkg;

   typedef enum logic [1:0] {
      DIAMOND = 2'd0,
      HEART   = 2'd1,
      CLUB    = 2'd2,
      SPADE   = 2'd3
   } suit_t;

   typedef logic [3:0] rank_t;

   typedef struct packed {
      rank_t rank;
      suit_t suit;
   } card_t;

   localparam int MAX_HAND   = 4;
   localparam int NUM_DIGITS = 8;

   // Active-low one-hot anode pattern for a digit index.
   function automatic logic [NUM_DIGITS-1:0] anode_onehot(input logic [2:0] digit);
      return ~(NUM_DIGITS'(1) << digit);
   endfunction

endpackage

// File: rtl/hand_digit_scanner_if.sv
// rtl/hand_digit_scanner_if.sv - card load handshake between card source and scanner
interface hand_digit_scanner_if;
   import hand_digit_scanner_pkg::*;

   logic  card_valid_in;
   rank_t card_rank_in;
   suit_t card_suit_in;
   logic  card_ready_out;

   modport master (
      output card_valid_in,
      output card_rank_in,
      output card_suit_in,
      input  card_ready_out
   );

   modport slave (
      input  card_valid_in,
      input  card_rank_in,
      input  card_suit_in,
      output card_ready_out
   );

endinterface

// File: rtl/hand_digit_scanner_seg_refresh_timer.sv
// rtl/hand_digit_scanner_seg_refresh_timer.sv - per-digit dwell counter and 3-bit digit index
module seg_refresh_timer #(
   parameter int REFRESH_CYCLES = 100_000
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   output logic [2:0] digit_out,
   output logic       tc_out
);

   localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   logic [CW-1:0] refresh_cnt;

   assign tc_out = (refresh_cnt == CW'(REFRESH_CYCLES - 1));

   // Dwell counter wraps at the terminal count and steps the digit index, which wraps 7 -> 0.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         refresh_cnt <= '0;
         digit_out   <= 3'd0;
      end else if (tc_out) begin
         refresh_cnt <= '0;
         digit_out   <= digit_out + 3'd1;
      end else begin
         refresh_cnt <= refresh_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/hand_digit_scanner.sv
// rtl/hand_digit_scanner.sv - 4-card hand buffer multiplexed onto 8 seven-segment digits; optional blink via SEG_BLINK_EN
module hand_digit_scanner
   import hand_digit_scanner_pkg::*;
#(
   parameter int REFRESH_CYCLES = 100_000,
   parameter int BLINK_CYCLES   = 25_000_000
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   hand_digit_scanner_if.slave   card_if,
   input  logic                  clear_in,
   input  logic [1:0]            blink_sel_in,
   input  logic                  blink_on_in,
   output logic [2:0]            count_out,
   output logic [NUM_DIGITS-1:0] an_out,
   output logic                  kind_out,
   output rank_t                 rank_out,
   output suit_t                 suit_out
);

   card_t                 slots [MAX_HAND];
   logic [2:0]            digit;
   logic                  unused_tc;
   logic [1:0]            card_idx;
   logic                  lit;
   logic                  blink_hide;
   logic                  accept;
   logic [NUM_DIGITS-1:0] an_next;
   rank_t                 rank_next;
   suit_t                 suit_next;

   seg_refresh_timer #(
      .REFRESH_CYCLES (REFRESH_CYCLES)
   ) u_timer (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .digit_out (digit),
      .tc_out    (unused_tc)
   );

   assign card_if.card_ready_out = (count_out < 3'(MAX_HAND)) && !clear_in;
   assign accept                 = card_if.card_valid_in && card_if.card_ready_out;
   assign card_idx               = digit[2:1];

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   logic [BW-1:0] blink_cnt;
   logic          blink_phase_off;

   // Blink phase starts "on" and toggles every BLINK_CYCLES clocks.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         blink_cnt       <= '0;
         blink_phase_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt       <= '0;
         blink_phase_off <= ~blink_phase_off;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // A selected card beyond the held count is never lit, so the select needs no range check here.
   assign blink_hide = blink_on_in && blink_phase_off && (card_idx == blink_sel_in);
`else
   logic unused_blink;

   assign blink_hide   = 1'b0;
   assign unused_blink = ^{blink_sel_in, blink_on_in, BLINK_CYCLES[0]};
`endif

   // Card buffer: clear only resets the count, slot contents persist until overwritten or reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_out <= 3'd0;
         for (int i = 0; i < MAX_HAND; i++) begin
            slots[i] <= '0;
         end
      end else if (clear_in) begin
         count_out <= 3'd0;
      end else if (accept) begin
         slots[count_out[1:0]] <= card_t'{rank: card_if.card_rank_in, suit: card_if.card_suit_in};
         count_out             <= count_out + 3'd1;
      end
   end

   // Digit decode: even digits carry the rank, odd digits the suit; unused code is held at zero.
   always_comb begin
      lit       = ({1'b0, card_idx} < count_out) && !blink_hide;
      an_next   = lit ? anode_onehot(digit) : '1;
      rank_next = digit[0] ? rank_t'(0) : slots[card_idx].rank;
      suit_next = digit[0] ? slots[card_idx].suit : DIAMOND;
   end

   // Registered display outputs, one clock behind the digit index and buffer state.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         an_out   <= '1;
         kind_out <= 1'b0;
         rank_out <= '0;
         suit_out <= DIAMOND;
      end else begin
         an_out   <= an_next;
         kind_out <= digit[0];
         rank_out <= rank_next;
         suit_out <= suit_next;
      end
   end

endmodule

// File: tb/tb_hand_digit_scanner.sv
// tb/tb_hand_digit_scanner.sv - randomized and directed checks against a cycle-counting hand model
module tb_hand_digit_scanner;
   import hand_digit_scanner_pkg::*;

   localparam int R = 4;
   localparam int B = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] blink_sel = 2'd0;
   logic       blink_on = 1'b0;
   logic [2:0] count;
   logic [7:0] an;
   logic       kind;
   rank_t      rank;
   suit_t      suit;

   hand_digit_scanner_if card_if ();

   hand_digit_scanner #(
      .REFRESH_CYCLES (R),
      .BLINK_CYCLES   (B)
   ) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .card_if      (card_if),
      .clear_in     (clear),
      .blink_sel_in (blink_sel),
      .blink_on_in  (blink_on),
      .count_out    (count),
      .an_out       (an),
      .kind_out     (kind),
      .rank_out     (rank),
      .suit_out     (suit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: edges since reset release, held count, and slot contents.
   int n = 0;
   int m_count = 0;
   int m_rank [4];
   int m_suit [4];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      m_count = 0;
      for (int i = 0; i < 4; i++) begin
         m_rank[i] = 0;
         m_suit[i] = 0;
      end
   endtask

   task automatic set_card(input bit v, input int r, input int s);
      card_if.card_valid_in = v;
      card_if.card_rank_in  = rank_t'(r);
      card_if.card_suit_in  = suit_t'(s);
   endtask

   // One clock: predict outputs from the pre-edge hand, apply load/clear, compare at the falling edge.
   task automatic cycle();
      int  d, k, e_an, e_kind, e_rank, e_suit;
      bit  show;
      @(posedge clk);
      d    = (n / R) % 8;
      k    = d / 2;
      show = (k < m_count);
`ifdef SEG_BLINK_EN
      if (blink_on && ((n / B) % 2 == 1) && (int'(blink_sel) == k))
         show = 1'b0;
`endif
      e_an   = show ? (255 - (1 << d)) : 255;
      e_kind = d % 2;
      e_rank = (d % 2 == 0) ? m_rank[k] : 0;
      e_suit = (d % 2 == 1) ? m_suit[k] : 0;
      if (clear) begin
         m_count = 0;
      end else if (card_if.card_valid_in && m_count < 4) begin
         m_rank[m_count] = int'(card_if.card_rank_in);
         m_suit[m_count] = int'(card_if.card_suit_in);
         m_count++;
      end
      n++;
      @(negedge clk);
      check_eq("an", an, e_an);
      check_eq("kind", kind, e_kind);
      check_eq("rank", rank, e_rank);
      check_eq("suit", suit, e_suit);
      check_eq("count", count, m_count);
      check_eq("ready", card_if.card_ready_out, (m_count < 4) && !clear);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) cycle();
   endtask

   task automatic load(input int r, input int s);
      set_card(1'b1, r, s);
      cycle();
      set_card(1'b0, 0, 0);
   endtask

   initial begin
      set_card(1'b0, 0, 0);
      model_reset();
      #12;
      check_eq("rst_an", an, 8'hFF);
      check_eq("rst_count", count, 0);
      check_eq("rst_kind", kind, 0);
      check_eq("rst_rank", rank, 0);
      check_eq("rst_suit", suit, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: all blank, ready high.
      run(64);
      check_eq("t1_an", an, 8'hFF);
      check_eq("t1_ready", card_if.card_ready_out, 1);

      // Two cards, then a full scan.
      load(12, 3);
      load(1, 0);
      check_eq("t2_count", count, 2);
      run(40);

      // Fill the hand and keep offering a fifth card.
      load(7, 1);
      load(13, 2);
      set_card(1'b1, 5, 1);
      run(40);
      check_eq("t3_ready", card_if.card_ready_out, 0);
      check_eq("t3_count", count, 4);
      set_card(1'b0, 0, 0);

      // Clear and valid together with three held.
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      load(2, 1);
      load(3, 2);
      load(4, 3);
      check_eq("t4_pre", count, 3);
      clear = 1'b1;
      set_card(1'b1, 9, 0);
      cycle();
      check_eq("t4_count", count, 0);
      clear = 1'b0;
      set_card(1'b0, 0, 0);
      cycle();
      check_eq("t4_blank", an, 8'hFF);
      run(10);

      // Asynchronous reset mid-digit with two held.
      load(10, 1);
      load(11, 2);
      run(9);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5_an", an, 8'hFF);
      check_eq("t5_count", count, 0);
      check_eq("t5_rank", rank, 0);
      check_eq("t5_suit", suit, 0);
      check_eq("t5_kind", kind, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      load(6, 2);
      run(36);

      // Randomized loads, clears and blink controls.
      for (int i = 0; i < 800; i++) begin
         set_card($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3));
         clear = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) begin
            blink_sel = 2'($urandom_range(0, 3));
            blink_on  = $urandom_range(0, 1) == 1;
         end
         cycle();
      end
      set_card(1'b0, 0, 0);
      clear    = 1'b0;
      blink_on = 1'b0;

`ifdef SEG_BLINK_EN
      // Blink card 1 with three held.
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      load(8, 0);
      load(9, 1);
      load(10, 2);
      blink_sel = 2'd1;
      blink_on  = 1'b1;
      run(96);
      blink_on  = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
